// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, FSM states,
// datapath select encodings and the decoded control word.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_R,
    ST_WB_I,
    ST_WB_MEM,
    ST_BRANCH,
    ST_JUMP,
    ST_TRAP
  } state_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    SRC_B_RT      = 2'd0,
    SRC_B_FOUR    = 2'd1,
    SRC_B_IMM     = 2'd2,
    SRC_B_IMM_SH2 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_rd;
    logic       dmem_wr;
    logic       ir_we;
    logic       pc_we;
    pc_src_t    pc_src;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       busy;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// State-to-control-word decode for multicycle_ctrl.
//   state    : current FSM state
//   imem_ack : gates IR/PC load in FETCH
//   zero     : gates PC load in BRANCH
//   ctrl     : full control word for the datapath
module ctrl_out_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       imem_ack,
  input  logic       zero,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.imem_req  = 1'b1;
        ctrl.ir_we     = imem_ack;
        ctrl.pc_we     = imem_ack;
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: ctrl.dmem_rd = 1'b1;
      ST_MEM_WR: ctrl.dmem_wr = 1'b1;
      ST_WB_R: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      ST_WB_I: ctrl.reg_we = 1'b1;
      ST_WB_MEM: begin
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_we     = zero;
        ctrl.pc_src    = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_we  = 1'b1;
        ctrl.pc_src = PC_SRC_JUMP;
      end
      default: ;
    endcase
    ctrl.busy = (state != ST_IDLE) && (state != ST_TRAP);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the MIPS-subset CPU.
// Holds the state register, next-state logic, sticky illegal flag and the
// retired-instruction counter; control outputs come from ctrl_out_decode.
//   clk_i/rst_i            : clock, async active-low reset
//   start_i                : run enable, sampled at instruction boundaries
//   opcode_i, zero_i       : IR opcode and ALU equality flag
//   imem_*/dmem_*          : memory request/ack handshakes
//   ir_we_o .. mem_to_reg_o: datapath selects and write enables
//   busy_o, illegal_o      : status; inst_cnt_o retired count
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  output logic             imem_req_o,
  output logic             dmem_rd_o,
  output logic             dmem_wr_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_we_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] inst_cnt_o
);

  state_t           state;
  logic             illegal_q;
  logic [CNT_W-1:0] inst_cnt_q;
  logic             retire;
  ctrl_word_t       ctrl;

  always_comb begin
    retire = 1'b0;
    case (state)
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: retire = 1'b1;
      ST_MEM_WR: retire = dmem_ack_i;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      illegal_q  <= 1'b0;
      inst_cnt_q <= '0;
    end else if (retire) begin
      inst_cnt_q <= inst_cnt_q + CNT_W'(1);
      state      <= start_i ? ST_FETCH : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start_i) state <= ST_FETCH;
        ST_FETCH:  if (imem_ack_i) state <= ST_DECODE;
        ST_DECODE: begin
          case (opcode_i)
            OP_RTYPE:     state <= ST_EXEC_R;
            OP_ADDI:      state <= ST_EXEC_I;
            OP_LW, OP_SW: state <= ST_MEM_ADDR;
            OP_BEQ:       state <= ST_BRANCH;
            OP_J:         state <= ST_JUMP;
            default: begin
              state     <= ST_TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        ST_EXEC_R:   state <= ST_WB_R;
        ST_EXEC_I:   state <= ST_WB_I;
        // Only lw/sw reach MEM_ADDR, so anything but sw is a load.
        ST_MEM_ADDR: state <= (opcode_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD:   if (dmem_ack_i) state <= ST_WB_MEM;
        default: ;
      endcase
    end
  end

  ctrl_out_decode u_decode (
    .state    (state),
    .imem_ack (imem_ack_i),
    .zero     (zero_i),
    .ctrl     (ctrl)
  );

  assign imem_req_o   = ctrl.imem_req;
  assign dmem_rd_o    = ctrl.dmem_rd;
  assign dmem_wr_o    = ctrl.dmem_wr;
  assign ir_we_o      = ctrl.ir_we;
  assign pc_we_o      = ctrl.pc_we;
  assign pc_src_o     = ctrl.pc_src;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign reg_we_o     = ctrl.reg_we;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign busy_o       = ctrl.busy;
  assign illegal_o    = illegal_q;
  assign inst_cnt_o   = inst_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam logic [5:0] T_ADDI = 6'b001000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010;

  logic clk = 1'b0;
  logic rst_i, start_i, zero_i, imem_ack_i, dmem_ack_i;
  logic [5:0] opcode_i;
  logic imem_req_o, dmem_rd_o, dmem_wr_o, ir_we_o, pc_we_o, alu_src_a_o;
  logic [1:0] pc_src_o, alu_src_b_o, alu_op_o;
  logic reg_we_o, reg_dst_o, mem_to_reg_o, busy_o, illegal_o;
  logic [CNT_W-1:0] inst_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .opcode_i(opcode_i),
    .zero_i(zero_i), .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
    .imem_req_o(imem_req_o), .dmem_rd_o(dmem_rd_o), .dmem_wr_o(dmem_wr_o),
    .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .reg_we_o(reg_we_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .busy_o(busy_o), .illegal_o(illegal_o), .inst_cnt_o(inst_cnt_o)
  );

  // ---------------- datapath driven purely by the controller outputs ----------
  logic [31:0] imem [64];
  logic [31:0] rf_init [32];
  logic [31:0] dmem_init [16];
  logic [31:0] rf [32];
  logic [31:0] dmem [16];
  logic [31:0] pc, ir, alu_out, mdr;
  logic [31:0] rs_val, rt_val, imm_sx, src_a, src_b, alu_res, wb_data;
  logic [4:0]  wb_dst;

  always_comb begin
    rs_val = rf[ir[25:21]];
    rt_val = rf[ir[20:16]];
    imm_sx = {{16{ir[15]}}, ir[15:0]};
    src_a  = alu_src_a_o ? rs_val : pc;
    case (alu_src_b_o)
      2'd0:    src_b = rt_val;
      2'd1:    src_b = 32'd4;
      2'd2:    src_b = imm_sx;
      default: src_b = imm_sx << 2;
    endcase
    case (alu_op_o)
      2'b01:   alu_res = src_a - src_b;
      2'b10:   alu_res = (ir[5:0] == 6'h22) ? src_a - src_b : src_a + src_b;
      default: alu_res = src_a + src_b;
    endcase
    wb_dst  = reg_dst_o ? ir[15:11] : ir[20:16];
    wb_data = mem_to_reg_o ? mdr : alu_out;
  end

  assign opcode_i = ir[31:26];
  assign zero_i   = (rs_val == rt_val);

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      pc <= '0;
      ir <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= rf_init[i];
      for (int i = 0; i < 16; i++) dmem[i] <= dmem_init[i];
    end else begin
      if (ir_we_o) ir <= imem[pc[7:2]];
      if (pc_we_o) begin
        case (pc_src_o)
          2'd0:    pc <= alu_res;
          2'd1:    pc <= alu_out;
          default: pc <= {pc[31:28], ir[25:0], 2'b00};
        endcase
      end
      // ALUOut keeps the effective address through memory wait states
      if (!(dmem_rd_o || dmem_wr_o)) alu_out <= alu_res;
      if (dmem_rd_o && dmem_ack_i) mdr <= dmem[alu_out[5:2]];
      if (dmem_wr_o && dmem_ack_i) dmem[alu_out[5:2]] <= rt_val;
      if (reg_we_o && wb_dst != 5'd0) rf[wb_dst] <= wb_data;
    end
  end

  // ---------------- ISA-level reference model ----------------
  logic [31:0] m_rf [32];
  logic [31:0] m_dmem [16];
  logic [31:0] m_pc;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] funct);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs,
                                        input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input int word_idx);
    return {T_J, 26'(word_idx)};
  endfunction

  task automatic model_sync();
    for (int i = 0; i < 32; i++) m_rf[i] = rf_init[i];
    for (int i = 0; i < 16; i++) m_dmem[i] = dmem_init[i];
    m_pc = '0;
  endtask

  // Executes one instruction architecturally; returns its expected cycle count.
  task automatic model_step(input int iw, input int dw, output int exp_cyc);
    logic [31:0] ins, a, b, imm, npc, addr;
    int rs, rt, rd;
    ins = imem[m_pc[7:2]];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    a = m_rf[rs]; b = m_rf[rt];
    imm = {{16{ins[15]}}, ins[15:0]};
    npc = m_pc + 32'd4;
    addr = a + imm;
    exp_cyc = 3 + iw;
    case (ins[31:26])
      6'b000000: begin
        if (rd != 0) m_rf[rd] = (ins[5:0] == 6'h22) ? a - b : a + b;
        exp_cyc = 4 + iw;
      end
      T_ADDI: begin
        if (rt != 0) m_rf[rt] = a + imm;
        exp_cyc = 4 + iw;
      end
      T_LW: begin
        if (rt != 0) m_rf[rt] = m_dmem[addr[5:2]];
        exp_cyc = 5 + iw + dw;
      end
      T_SW: begin
        m_dmem[addr[5:2]] = b;
        exp_cyc = 4 + iw + dw;
      end
      T_BEQ: if (a == b) npc = npc + (imm << 2);
      default: npc = {npc[31:28], ins[25:0], 2'b00};
    endcase
    m_pc = npc;
  endtask

  // ---------------- stimulus helpers ----------------
  int   we_cycle, rd_cycles;
  logic we_dst, last_pc_we;

  task automatic clear_env();
    for (int i = 0; i < 64; i++) imem[i] = '0;
    for (int i = 0; i < 32; i++) rf_init[i] = '0;
    for (int i = 0; i < 16; i++) dmem_init[i] = '0;
  endtask

  task automatic apply_reset();
    start_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  // Called at a negedge with the controller in FETCH; returns at the negedge
  // after the retiring edge.
  task automatic run_instr(input int iw, input int dw, input bit drop_start,
                           input bit noise, output int cycles);
    int ic, dc;
    bit done;
    logic [CNT_W-1:0] c0;
    ic = 0; dc = 0; cycles = 0; done = 0; c0 = inst_cnt_o;
    we_cycle = 0; we_dst = 1'b0; rd_cycles = 0; last_pc_we = 1'b0;
    while (!done && cycles < 60) begin
      #1;
      imem_ack_i = noise ? 1'($urandom) : 1'b0;
      dmem_ack_i = noise ? 1'($urandom) : 1'b0;
      if (imem_req_o) begin imem_ack_i = (ic == iw); ic++; end
      if (dmem_rd_o || dmem_wr_o) begin
        dmem_ack_i = (dc == dw); dc++;
        if (dmem_rd_o) rd_cycles++;
        if (drop_start && dmem_wr_o) start_i = 1'b0;
      end
      cycles++;
      #1;
      vectors++;
      if (ir_we_o !== (imem_req_o & imem_ack_i)) begin
        miscompares++;
        $display("FAIL ir_we: got %b want %b", ir_we_o, imem_req_o & imem_ack_i);
      end
      if (imem_req_o && imem_ack_i) begin
        vectors++;
        if ({pc_we_o, pc_src_o, alu_src_a_o, alu_src_b_o} !== 6'b1_00_0_01) begin
          miscompares++;
          $display("FAIL fetch_ctl: got %b want 100001",
                   {pc_we_o, pc_src_o, alu_src_a_o, alu_src_b_o});
        end
      end
      if (reg_we_o && we_cycle == 0) begin we_cycle = cycles; we_dst = reg_dst_o; end
      last_pc_we = pc_we_o;
      @(posedge clk); #1;
      if (inst_cnt_o !== c0) done = 1;
      imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
      @(negedge clk);
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL retire_timeout: got no retire after %0d cycles want retire", cycles);
    end
  endtask

  task automatic start_run();
    start_i = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_env();
    apply_reset();
    #1;
    vectors++;
    if ({imem_req_o, dmem_rd_o, dmem_wr_o, ir_we_o, pc_we_o, reg_we_o, busy_o,
         illegal_o, inst_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got req%b rd%b wr%b busy%b ill%b cnt%0d want all 0",
               imem_req_o, dmem_rd_o, dmem_wr_o, busy_o, illegal_o, inst_cnt_o);
    end
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (imem_req_o !== 1'b0) begin
      miscompares++; $display("FAIL idle_hold: got req %b want 0", imem_req_o);
    end
    start_run();
    #1;
    vectors++;
    if ({imem_req_o, busy_o} !== 2'b11) begin
      miscompares++; $display("FAIL fetch_entry: got req/busy %b want 11", {imem_req_o, busy_o});
    end
    rst_i = 1'b0;
    #1;
    vectors++;
    if ({imem_req_o, busy_o} !== 2'b00) begin
      miscompares++; $display("FAIL async_reset: got req/busy %b want 00", {imem_req_o, busy_o});
    end
    @(negedge clk);
    rst_i = 1'b1; start_i = 1'b0;
  endtask

  task automatic test_add();
    int cyc;
    clear_env();
    imem[0] = enc_r(1, 2, 3, 6'h20);
    rf_init[1] = 32'd5; rf_init[2] = 32'd7;
    apply_reset();
    start_run();
    run_instr(0, 0, 0, 0, cyc);
    vectors++;
    if (cyc !== 4) begin miscompares++; $display("FAIL add_cycles: got %0d want 4", cyc); end
    vectors++;
    if (we_cycle !== 4 || we_dst !== 1'b1) begin
      miscompares++; $display("FAIL add_wb: got cycle %0d dst %b want 4 1", we_cycle, we_dst);
    end
    vectors++;
    if (rf[3] !== 32'd12) begin miscompares++; $display("FAIL add_result: got %0d want 12", rf[3]); end
    vectors++;
    if (inst_cnt_o !== CNT_W'(1)) begin
      miscompares++; $display("FAIL add_count: got %0d want 1", inst_cnt_o);
    end
  endtask

  task automatic test_lw_wait();
    int cyc;
    clear_env();
    imem[0] = enc_i(T_LW, 0, 4, 16'd8);
    dmem_init[2] = 32'hCAFE_0001;
    apply_reset();
    start_run();
    run_instr(0, 3, 0, 0, cyc);
    vectors++;
    if (rd_cycles !== 4) begin miscompares++; $display("FAIL lw_rd_len: got %0d want 4", rd_cycles); end
    vectors++;
    if (cyc !== 8 || we_cycle !== 8) begin
      miscompares++; $display("FAIL lw_cycles: got %0d/%0d want 8/8", cyc, we_cycle);
    end
    vectors++;
    if (rf[4] !== 32'hCAFE_0001) begin
      miscompares++; $display("FAIL lw_data: got %h want cafe0001", rf[4]);
    end
  endtask

  task automatic test_beq(input bit taken);
    int cyc;
    logic [31:0] exp_pc;
    clear_env();
    imem[0] = enc_j(4);
    imem[4] = enc_i(T_BEQ, 4, 5, 16'd2);
    rf_init[4] = 32'd9;
    rf_init[5] = taken ? 32'd9 : 32'd8;
    exp_pc = taken ? 32'h1C : 32'h14;
    apply_reset();
    start_run();
    run_instr(0, 0, 0, 0, cyc);
    vectors++;
    if (pc !== 32'h10 || cyc !== 3) begin
      miscompares++; $display("FAIL jump_pc: got pc %h cyc %0d want 10 3", pc, cyc);
    end
    run_instr(1, 0, 0, 0, cyc);
    vectors++;
    if (last_pc_we !== taken || cyc !== 4) begin
      miscompares++;
      $display("FAIL beq_pc_we: got we %b cyc %0d want %b 4", last_pc_we, cyc, taken);
    end
    vectors++;
    if (pc !== exp_pc) begin miscompares++; $display("FAIL beq_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_sw_stop();
    int cyc;
    bit seen;
    clear_env();
    imem[0] = enc_i(T_SW, 0, 6, 16'd12);
    rf_init[6] = 32'h1234_5678;
    apply_reset();
    start_run();
    run_instr(1, 2, 1, 0, cyc);
    vectors++;
    if (cyc !== 7 || dmem[3] !== 32'h1234_5678) begin
      miscompares++; $display("FAIL sw_store: got cyc %0d mem %h want 7 12345678", cyc, dmem[3]);
    end
    vectors++;
    if (busy_o !== 1'b0 || inst_cnt_o !== CNT_W'(1)) begin
      miscompares++; $display("FAIL sw_idle: got busy %b cnt %0d want 0 1", busy_o, inst_cnt_o);
    end
    seen = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (imem_req_o !== 1'b0) seen = 1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL sw_no_fetch: got req 1 want 0"); end
  endtask

  task automatic test_trap();
    bit seen;
    clear_env();
    imem[0] = 32'hFC00_0000;
    apply_reset();
    start_run();
    #1 imem_ack_i = 1'b1;
    @(posedge clk); #1 imem_ack_i = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({illegal_o, busy_o} !== 2'b10) begin
      miscompares++; $display("FAIL trap_entry: got ill/busy %b want 10", {illegal_o, busy_o});
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk); #1;
      imem_ack_i = 1'($urandom); dmem_ack_i = 1'($urandom);
      #1;
      if ({imem_req_o, dmem_rd_o, dmem_wr_o, ir_we_o, pc_we_o, reg_we_o} !== '0) seen = 1;
    end
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
    vectors++;
    if (seen || illegal_o !== 1'b1) begin
      miscompares++; $display("FAIL trap_hold: got strobe %b ill %b want 0 1", seen, illegal_o);
    end
    rst_i = 1'b0;
    #1;
    vectors++;
    if (illegal_o !== 1'b0) begin miscompares++; $display("FAIL trap_clear: got %b want 0", illegal_o); end
    @(negedge clk);
    rst_i = 1'b1; start_i = 1'b0;
  endtask

  task automatic test_random();
    int cyc, exp_cyc, iw, dw, exp_cnt, kind, imm_v;
    clear_env();
    for (int i = 1; i < 8; i++) rf_init[i] = $urandom_range(0, 40);
    for (int i = 0; i < 16; i++) dmem_init[i] = $urandom;
    for (int i = 0; i < 64; i++) begin
      kind = $urandom_range(0, 6);
      imm_v = int'($urandom_range(0, 16)) - 8;
      case (kind)
        0: imem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 7), 6'h20);
        1: imem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 7), 6'h22);
        2: imem[i] = enc_i(T_ADDI, $urandom_range(0, 7), $urandom_range(1, 7), 16'(imm_v));
        3: imem[i] = enc_i(T_LW, 0, $urandom_range(1, 7), 16'(4 * $urandom_range(0, 15)));
        4: imem[i] = enc_i(T_SW, 0, $urandom_range(0, 7), 16'(4 * $urandom_range(0, 15)));
        5: imem[i] = enc_i(T_BEQ, $urandom_range(1, 3), $urandom_range(1, 3), 16'(imm_v));
        default: imem[i] = enc_j($urandom_range(0, 63));
      endcase
    end
    apply_reset();
    model_sync();
    start_run();
    exp_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      iw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      model_step(iw, dw, exp_cyc);
      run_instr(iw, dw, 0, 1, cyc);
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      vectors++;
      if (cyc !== exp_cyc || pc !== m_pc || inst_cnt_o !== CNT_W'(exp_cnt)) begin
        miscompares++;
        $display("FAIL rand_step%0d: got cyc %0d pc %h cnt %0d want %0d %h %0d",
                 n, cyc, pc, inst_cnt_o, exp_cyc, m_pc, exp_cnt);
      end
    end
    for (int i = 1; i < 8; i++) begin
      vectors++;
      if (rf[i] !== m_rf[i]) begin
        miscompares++; $display("FAIL rand_reg%0d: got %h want %h", i, rf[i], m_rf[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (dmem[i] !== m_dmem[i]) begin
        miscompares++; $display("FAIL rand_mem%0d: got %h want %h", i, dmem[i], m_dmem[i]);
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc;
    clear_env();
    imem[0] = enc_j(0);
    apply_reset();
    start_run();
    for (int n = 0; n < (1 << CNT_W) - 1; n++) run_instr(0, 0, 0, 0, cyc);
    vectors++;
    if (inst_cnt_o !== '1) begin
      miscompares++; $display("FAIL wrap_full: got %0d want %0d", inst_cnt_o, (1 << CNT_W) - 1);
    end
    run_instr(0, 0, 0, 0, cyc);
    vectors++;
    if (inst_cnt_o !== '0 || pc !== 32'h0) begin
      miscompares++; $display("FAIL wrap_zero: got cnt %0d pc %h want 0 0", inst_cnt_o, pc);
    end
    start_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw_stop();
    test_trap();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want $finish");
    $fatal(1);
  end

endmodule
